// File: rtl/operand_field_decoder_if.sv
// Source-operand handshake bundle: instruction in, decoded register/immediate fields out.
// Optional macro OPDEC_ILLEGAL_EN adds the per-entry illegal flag.
interface operand_field_decoder_if #(
  parameter int IMM_W = 22,
  parameter int IS_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [IMM_W-1:0] imm;
  logic [IS_W-1:0]  is;
`ifdef OPDEC_ILLEGAL_EN
  logic             illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, rs1, rs2, rd, imm, is, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, rs1, rs2, rd, imm, is, illegal
  );
`else
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, rs1, rs2, rd, imm, is
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, rs1, rs2, rd, imm, is
  );
`endif
endinterface

// File: rtl/operand_field_decoder.sv
// Slices SPARC instructions into rs1/rs2/rd, Imm and IS select behind a 2-entry skid buffer.
// Define OPDEC_ILLEGAL_EN to flag UNIMP/reserved op=00 encodings on the illegal output.
module operand_field_decoder #(
  parameter int IMM_W = 22,
  parameter int IS_W  = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic                    flush,
  operand_field_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [IMM_W-1:0] imm;
    logic [IS_W-1:0]  is;
`ifdef OPDEC_ILLEGAL_EN
    logic             illegal;
`endif
  } entry_t;

  state_t state;
  state_t next_state;
  entry_t dec;
  entry_t head;
  entry_t skid;
  logic   push;
  logic   pop;
  logic   load_head_new;
  logic   load_head_skid;
  logic   load_skid_new;
  logic   is_shift;

  // Shift ops (SLL/SRL/SRA) take their count from bits [4:0] rather than simm13.
  assign is_shift = (bus.instr[24:19] == 6'h25) ||
                    (bus.instr[24:19] == 6'h26) ||
                    (bus.instr[24:19] == 6'h27);

  always_comb begin
    dec     = '0;
    dec.rd  = bus.instr[29:25];
    dec.rs1 = bus.instr[18:14];
    dec.rs2 = bus.instr[4:0];
    case (bus.instr[31:30])
      2'b00: begin
        case (bus.instr[24:22])
          3'b100: begin
            dec.is  = IS_W'(4'b0001);
            dec.imm = IMM_W'(bus.instr[21:0]);
          end
          3'b010, 3'b110: begin
            dec.is  = IS_W'(4'b0010);
            dec.imm = IMM_W'(bus.instr[21:0]);
          end
          default: begin
`ifdef OPDEC_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
          end
        endcase
      end
      2'b01: begin
        dec.is  = IS_W'(4'b1111);
        dec.imm = IMM_W'(bus.instr[21:0]);
      end
      default: begin
        if (bus.instr[13]) begin
          if (is_shift) begin
            dec.is  = IS_W'(4'b0101);
            dec.imm = {{(IMM_W-5){1'b0}}, bus.instr[4:0]};
          end else begin
            dec.is  = IS_W'(4'b0100);
            dec.imm = {{(IMM_W-13){bus.instr[12]}}, bus.instr[12:0]};
          end
        end else begin
          dec.is = is_shift ? IS_W'(4'b0110) : IS_W'(4'b0000);
        end
      end
    endcase
  end

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid_new  = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          next_state    = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          next_state    = FULL;
          load_skid_new = 1'b1;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          next_state     = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush wins over any same-cycle transfer, so nothing is loaded either.
    if (flush) begin
      next_state     = EMPTY;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid_new  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_new) begin
        head <= dec;
      end else if (load_head_skid) begin
        head <= skid;
      end
      if (load_skid_new) begin
        skid <= dec;
      end
    end
  end

  assign bus.rd  = head.rd;
  assign bus.rs1 = head.rs1;
  assign bus.rs2 = head.rs2;
  assign bus.imm = head.imm;
  assign bus.is  = head.is;
`ifdef OPDEC_ILLEGAL_EN
  assign bus.illegal = head.illegal;
`endif

endmodule

// File: tb/tb_operand_field_decoder.sv
// Directed bench for operand_field_decoder: hand-decoded vectors go into a scoreboard queue,
// a negedge monitor pops and compares each output transfer.
module tb_operand_field_decoder;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [21:0] imm;
    logic [3:0]  is;
    logic        ill;
  } exp_t;

`ifdef OPDEC_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  operand_field_decoder_if bus ();

  operand_field_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [21:0] imm, input logic [3:0] is, input logic ill);
    exp_t e;
    e.rd  = rd;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.imm = imm;
    e.is  = is;
    e.ill = ill;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the instruction.
  task automatic applyStimulus(input logic [31:0] ins, input exp_t e);
    bit done = 1'b0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    while (!done && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: instr %h not accepted within 50 cycles", ins);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      exp_t got;
      exp_t want;
`ifdef OPDEC_ILLEGAL_EN
      got = mk(bus.rd, bus.rs1, bus.rs2, bus.imm, bus.is, bus.illegal);
`else
      got = mk(bus.rd, bus.rs1, bus.rs2, bus.imm, bus.is, 1'b0);
`endif
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got rd=%0d rs1=%0d rs2=%0d imm=%h is=%b, expected nothing",
                 got.rd, got.rs1, got.rs2, got.imm, got.is);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL decode: got rd=%0d rs1=%0d rs2=%0d imm=%h is=%b ill=%b, expected rd=%0d rs1=%0d rs2=%0d imm=%h is=%b ill=%b",
                   got.rd, got.rs1, got.rs2, got.imm, got.is, got.ill,
                   want.rd, want.rs1, want.rs2, want.imm, want.is, want.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("reset_rd", {27'b0, bus.rd}, 32'd0);
    checkOutput("reset_imm", {10'b0, bus.imm}, 32'd0);
    checkOutput("reset_is", {28'b0, bus.is}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] streaming decode vectors");
    bus.out_ready = 1'b1;
    applyStimulus(32'h033FFFFF, mk(5'd1, 5'd31, 5'd31, 22'h3FFFFF, 4'b0001, 1'b0));
    applyStimulus(32'h8400FFFF, mk(5'd2, 5'd3, 5'd31, 22'h3FFFFF, 4'b0100, 1'b0));
    applyStimulus(32'h8529A005, mk(5'd2, 5'd6, 5'd5, 22'h000005, 4'b0101, 1'b0));
    applyStimulus(32'h85290002, mk(5'd2, 5'd4, 5'd2, 22'h000000, 4'b0110, 1'b0));
    applyStimulus(32'h10800000, mk(5'd8, 5'd0, 5'd0, 22'h000000, 4'b0010, 1'b0));
    applyStimulus(32'h13800004, mk(5'd9, 5'd0, 5'd4, 22'h000004, 4'b0010, 1'b0));
    applyStimulus(32'h7FFFFFFF, mk(5'd31, 5'd31, 5'd31, 22'h3FFFFF, 4'b1111, 1'b0));
    applyStimulus(32'hC4002008, mk(5'd2, 5'd0, 5'd8, 22'h000008, 4'b0100, 1'b0));
    applyStimulus(32'h86010002, mk(5'd3, 5'd4, 5'd2, 22'h000000, 4'b0000, 1'b0));
    applyStimulus(32'h84006FFF, mk(5'd2, 5'd1, 5'd31, 22'h000FFF, 4'b0100, 1'b0));
    applyStimulus(32'h84003000, mk(5'd2, 5'd0, 5'd0, 22'h3FF000, 4'b0100, 1'b0));
    applyStimulus(32'h81202005, mk(5'd0, 5'd0, 5'd5, 22'h000005, 4'b0100, 1'b0));
    applyStimulus(32'h81380003, mk(5'd0, 5'd0, 5'd3, 22'h000000, 4'b0110, 1'b0));
    applyStimulus(32'h00000000, mk(5'd0, 5'd0, 5'd0, 22'h000000, 4'b0000, ILL));
    applyStimulus(32'h01C00123, mk(5'd0, 5'd0, 5'd3, 22'h000000, 4'b0000, ILL));
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] backpressure: three pushes with out_ready low");
    bus.out_ready = 1'b0;
    applyStimulus(32'h033FFFFF, mk(5'd1, 5'd31, 5'd31, 22'h3FFFFF, 4'b0001, 1'b0));
    checkOutput("one_in_ready", {31'b0, bus.in_ready}, 32'd1);
    applyStimulus(32'h8400FFFF, mk(5'd2, 5'd3, 5'd31, 22'h3FFFFF, 4'b0100, 1'b0));
    checkOutput("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
    fork
      applyStimulus(32'h8529A005, mk(5'd2, 5'd6, 5'd5, 22'h000005, 4'b0101, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("stall_head_rd", {27'b0, bus.rd}, 32'd1);
        checkOutput("stall_head_is", {28'b0, bus.is}, 32'd1);
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drained_out_valid", {31'b0, bus.out_valid}, 32'd0);

    $display("[TB] flush from FULL with in_valid high");
    bus.out_ready = 1'b0;
    applyStimulus(32'h10800000, mk(5'd8, 5'd0, 5'd0, 22'h000000, 4'b0010, 1'b0));
    applyStimulus(32'h7FFFFFFF, mk(5'd31, 5'd31, 5'd31, 22'h3FFFFF, 4'b1111, 1'b0));
    checkOutput("pre_flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr    = 32'h8400FFFF;
    @(posedge clk);
    sb.delete();
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("flush_dropped_input", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    applyStimulus(32'hC4002008, mk(5'd2, 5'd0, 5'd8, 22'h000008, 4'b0100, 1'b0));
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] asynchronous reset mid-stream");
    bus.out_ready = 1'b0;
    applyStimulus(32'h8529A005, mk(5'd2, 5'd6, 5'd5, 22'h000005, 4'b0101, 1'b0));
    applyStimulus(32'h85290002, mk(5'd2, 5'd4, 5'd2, 22'h000000, 4'b0110, 1'b0));
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("async_rst_imm", {10'b0, bus.imm}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(32'h13800004, mk(5'd9, 5'd0, 5'd4, 22'h000004, 4'b0010, 1'b0));

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    checkOutput("final_out_valid", {31'b0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
